// File: rtl/alu_pkg.sv
// alu_pkg: operator, ASCII, error codes and parser states shared by the ALU front end
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_9 = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL = 8'h2A;
  localparam logic [7:0] CH_DIV = 8'h2F;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHAR = 2'b01;
  localparam logic [1:0] ERR_OVF = 2'b10;
  localparam logic [1:0] ERR_MISSING = 2'b11;
  typedef enum logic [1:0] {S_A, S_B, S_ERR} state_t;
  function automatic logic [1:0] op_code(input logic [7:0] c);
    return c == CH_MINUS ? OP_SUB : c == CH_MUL ? OP_MUL : c == CH_DIV ? OP_DIV : OP_ADD;
  endfunction
endpackage

// File: rtl/dec_accum.sv
// dec_accum: decimal digit accumulator with overflow detect and digit-seen flag
module dec_accum #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [3:0]        digit,
  output logic [DATA_W-1:0] value,
  output logic              nonzero_cnt,
  output logic              ovf
);
  logic [DATA_W+3:0] nxt;
  assign nxt = (DATA_W+4)'(value) * (DATA_W+4)'(10) + (DATA_W+4)'(digit);
  assign ovf = |nxt[DATA_W+3:DATA_W];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      value <= '0;
      nonzero_cnt <= 1'b0;
    end else if (clr) begin
      value <= '0;
      nonzero_cnt <= 1'b0;
    end else if (en) begin
      value <= nxt[DATA_W-1:0];
      nonzero_cnt <= 1'b1;
    end
endmodule

// File: rtl/expr_parser.sv
// expr_parser: parses ASCII "<A><op><B>=" into binary operands and an operator code
module expr_parser
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit SKIP_WS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [1:0]        op,
  output logic              out_valid,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic              busy
);
  state_t state;
  logic [1:0] op_reg, code;
  logic [DATA_W-1:0] acc_a, acc_b;
  logic seen_a, seen_b, ovf_a, ovf_b, en_a, en_b, err, commit, to_a, to_b;
  logic is_digit, is_op, is_eq, is_ws;
  assign is_digit = rx_data >= CH_0 && rx_data <= CH_9;
  assign is_op = rx_data == CH_PLUS || rx_data == CH_MINUS || rx_data == CH_MUL || rx_data == CH_DIV;
  assign is_eq = rx_data == CH_EQ;
  assign is_ws = SKIP_WS && (rx_data == CH_SP || rx_data == CH_CR || rx_data == CH_LF);
  assign busy = state != S_A || seen_a;
  always_comb begin
    en_a = 1'b0;
    en_b = 1'b0;
    err = 1'b0;
    code = ERR_NONE;
    commit = 1'b0;
    to_a = 1'b0;
    to_b = 1'b0;
    if (rx_valid && !is_ws) begin
      if (state == S_A) begin
        if (is_digit) begin
          en_a = 1'b1;
          err = ovf_a;
          code = ERR_OVF;
        end else if (is_op && seen_a) to_b = 1'b1;
        else begin
          err = 1'b1;
          code = (is_op || is_eq) ? ERR_MISSING : ERR_CHAR;
        end
      end else if (state == S_B) begin
        if (is_digit) begin
          en_b = 1'b1;
          err = ovf_b;
          code = ERR_OVF;
        end else if (is_eq && seen_b) commit = 1'b1;
        else begin
          err = 1'b1;
          code = is_eq ? ERR_MISSING : ERR_CHAR;
        end
      end else to_a = is_eq || rx_data == CH_LF;
    end
  end
  dec_accum #(.DATA_W(DATA_W)) u_acc_a (
    .clk(clk), .rst(rst), .clr(err || commit), .en(en_a), .digit(rx_data[3:0]),
    .value(acc_a), .nonzero_cnt(seen_a), .ovf(ovf_a)
  );
  dec_accum #(.DATA_W(DATA_W)) u_acc_b (
    .clk(clk), .rst(rst), .clr(err || commit), .en(en_b), .digit(rx_data[3:0]),
    .value(acc_b), .nonzero_cnt(seen_b), .ovf(ovf_b)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_A;
      op_reg <= OP_ADD;
      a <= '0;
      b <= '0;
      op <= OP_ADD;
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      out_valid <= commit;
      err_valid <= err;
      if (err) begin
        err_code <= code;
        state <= S_ERR;
      end else if (commit) begin
        a <= acc_a;
        b <= acc_b;
        op <= op_reg;
        state <= S_A;
      end else if (to_b) begin
        op_reg <= op_code(rx_data);
        state <= S_B;
      end else if (to_a) state <= S_A;
    end
endmodule
